// File: rtl/mc_datapath.sv
// mc_datapath: multicycle datapath for a 16-bit instruction set with a
// FETCH/DECODE/EXEC/MEM/WB/HALT controller and a 16-entry register file.
module mc_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] pc,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic [WIDTH-1:0] aluout
);
    generate
        if (NREGS != 16) begin : g_bad_nregs
            $error("mc_datapath: NREGS must be 16");
        end
        if (WIDTH < 16 || WIDTH > 64) begin : g_bad_width
            $error("mc_datapath: WIDTH must be 16..64");
        end
    endgenerate

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_halted;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;

    logic [3:0]       w_op;
    logic [3:0]       w_rs;
    logic [3:0]       w_rt;
    logic [3:0]       w_rd;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_pc1;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_npc;
    logic             w_rtype;
    logic             w_is_mem;
    logic [3:0]       w_dst;
    logic [WIDTH-1:0] w_wb;
    state_t           w_exec_next;

    assign w_op     = r_ir[15:12];
    assign w_rs     = r_ir[11:8];
    assign w_rt     = r_ir[7:4];
    assign w_rd     = r_ir[3:0];
    assign w_imm    = {{(WIDTH-4){r_ir[3]}}, r_ir[3:0]};
    assign w_pc1    = r_pc + 1'b1;
    assign w_rtype  = w_op <= OP_SLT;
    assign w_is_mem = w_op == OP_LW || w_op == OP_SW;
    assign w_dst    = w_rtype ? w_rd : w_rt;
    assign w_wb     = w_op == OP_LW ? r_mdr : r_alu;

    assign w_res = w_op == OP_ADD ? r_a + r_b :
                   w_op == OP_SUB ? r_a - r_b :
                   w_op == OP_AND ? r_a & r_b :
                   w_op == OP_OR  ? r_a | r_b :
                   w_op == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(r_a) < $signed(r_b)} :
                   r_a + w_imm;

    assign w_npc = w_op == OP_BEQ  ? (r_a == r_b ? w_pc1 + w_imm : w_pc1) :
                   w_op == OP_J    ? {r_pc[WIDTH-1:12], r_ir[11:0]} :
                   w_op == OP_HALT ? r_pc :
                   w_pc1;

    assign w_exec_next = (w_rtype || w_op == OP_ADDI) ? WB :
                         w_is_mem                     ? MEM :
                         w_op == OP_HALT              ? HALT :
                         FETCH;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_pc        <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu       <= '0;
            r_mdr       <= '0;
            r_halted    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_a     <= r_regs[w_rs];
                    r_b     <= r_regs[w_rt];
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_alu    <= w_res;
                    r_pc     <= w_npc;
                    r_halted <= w_op == OP_HALT;
                    // memory outputs are registered here so they are already stable on the first MEM cycle
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_op == OP_SW;
                        r_mem_addr  <= w_res;
                        r_mem_wdata <= r_b;
                    end
                    r_state <= w_exec_next;
                end
                MEM: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mdr     <= mem_rdata;
                        r_state   <= w_op == OP_LW ? WB : FETCH;
                    end
                end
                WB: begin
                    if (w_dst != 4'd0) r_regs[w_dst] <= w_wb;
                    r_state <= FETCH;
                end
                HALT: r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign pc        = r_pc;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign halted    = r_halted;
    assign aluout    = r_alu;
endmodule
